storeenc: RTL and testbench

//  Store-side counterpart of the pipeline load decoder. Takes a store from the MEM

---
 rtl/storeenc_if.sv | 29 ++
 rtl/storeenc.sv | 132 +++++++++++++
 tb/tb_storeenc.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/storeenc_if.sv
// Store-request and data-memory write bundle for storeenc.
// slave is the storeenc side; master is the upstream stage plus memory.
interface storeenc_if #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32
);
    logic                     ivalid;
    logic                     oready;
    logic [MP_ADDR_WIDTH-1:0] iaddr;
    logic [MP_DATA_WIDTH-1:0] iwdata;
    logic [2:0]               ifunct3;
    logic                     omem_req;
    logic                     imem_ack;
    logic [MP_ADDR_WIDTH-1:0] omem_addr;
    logic [MP_DATA_WIDTH-1:0] omem_wdata;
    logic [3:0]               omem_be;
    logic                     odone;
    logic                     oerr;

    modport slave (
        input  ivalid, iaddr, iwdata, ifunct3, imem_ack,
        output oready, omem_req, omem_addr, omem_wdata, omem_be, odone, oerr
    );

    modport master (
        output ivalid, iaddr, iwdata, ifunct3, imem_ack,
        input  oready, omem_req, omem_addr, omem_wdata, omem_be, odone, oerr
    );
endinterface

// File: rtl/storeenc.sv
// Store encoder: word-aligns the address, lane-rotates data/byte enables and runs the
// memory write handshake. Optional STOREENC_ALIGN_CHECK_EN rejects misaligned sh/sw.
module storeenc #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32,
    parameter int MP_TIMEOUT    = 16
) (
    input  logic       iclk,
    input  logic       irst,
    storeenc_if.slave  bus
);
    localparam int CNT_W = $clog2(MP_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e                   state_q, state_d;
    logic [MP_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [MP_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]               be_q,    be_d;
    logic                     err_q,   err_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;

    logic [1:0]               off;
    logic                     legal;
    logic                     reject;
    logic [MP_DATA_WIDTH-1:0] base_data, enc_data;
    logic [3:0]               base_be,   enc_be;

    // sw ignores the offset, so it is forced to zero before rotating.
    always_comb begin
        base_data = '0;
        base_be   = 4'b0000;
        legal     = 1'b1;
        off       = bus.iaddr[1:0];
        case (bus.ifunct3)
            3'b000: begin
                base_data = {24'b0, bus.iwdata[7:0]};
                base_be   = 4'b0001;
            end
            3'b001: begin
                base_data = {16'b0, bus.iwdata[15:0]};
                base_be   = 4'b0011;
            end
            3'b010: begin
                base_data = bus.iwdata;
                base_be   = 4'b1111;
                off       = 2'd0;
            end
            default: legal = 1'b0;
        endcase

        case (off)
            2'd1:    begin enc_data = {base_data[23:0], base_data[31:24]}; enc_be = {base_be[2:0], base_be[3]};   end
            2'd2:    begin enc_data = {base_data[15:0], base_data[31:16]}; enc_be = {base_be[1:0], base_be[3:2]}; end
            2'd3:    begin enc_data = {base_data[7:0],  base_data[31:8]};  enc_be = {base_be[0],   base_be[3:1]}; end
            default: begin enc_data = base_data;                           enc_be = base_be;                      end
        endcase
    end

`ifdef STOREENC_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((bus.ifunct3 == 3'b001) && (bus.iaddr[1:0] == 2'd3)) ||
                      ((bus.ifunct3 == 3'b010) && (bus.iaddr[1:0] != 2'd0));
    assign reject   = !legal || misalign;
`else
    assign reject   = !legal;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ivalid) begin
                    addr_d  = {bus.iaddr[MP_ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = enc_data;
                    be_d    = enc_be;
                    cnt_d   = '0;
                    err_d   = reject;
                    state_d = reject ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // An ack in the last allowed cycle still counts as success.
                if (bus.imem_ack) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(MP_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.oready     = (state_q == S_IDLE);
        bus.omem_req   = (state_q == S_REQ);
        bus.omem_be    = (state_q == S_REQ) ? be_q : 4'b0000;
        bus.omem_addr  = addr_q;
        bus.omem_wdata = wdata_q;
        bus.odone      = (state_q == S_DONE);
        bus.oerr       = (state_q == S_DONE) && err_q;
    end
endmodule

// File: tb/tb_storeenc.sv
// Self-checking bench for storeenc: directed table, reset corner case and
// randomized stores checked against a byte-lane reference model.
module tb_storeenc;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    storeenc_if #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32)) bus ();

    storeenc #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_TIMEOUT(TO)) dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        int          ack_at;
        logic        rej;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic        exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic garbage();
        bus.ivalid  = 1'($urandom);
        bus.iaddr   = $urandom;
        bus.iwdata  = $urandom;
        bus.ifunct3 = 3'($urandom);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    endfunction

    // Reference: byte i of the store lands in lane (off+i) mod 4.
    function automatic void model(input logic [31:0] addr, input logic [31:0] d, input logic [2:0] f3,
                                  output logic rej, output logic [31:0] ea, output logic [31:0] ew,
                                  output logic [3:0] eb);
        int n;
        int off;
        int lane;
        rej = (f3 > 3'b010);
`ifdef STOREENC_ALIGN_CHECK_EN
        if ((f3 == 3'b001 && addr[1:0] == 2'd3) || (f3 == 3'b010 && addr[1:0] != 2'd0)) rej = 1'b1;
`endif
        n   = size_of(f3);
        off = (f3 == 3'b010) ? 0 : int'(addr[1:0]);
        ea  = addr & 32'hFFFF_FFFC;
        ew  = '0;
        eb  = '0;
        for (int i = 0; i < n; i++) begin
            lane = (off + i) % 4;
            eb[lane] = 1'b1;
            ew[lane*8 +: 8] = d[i*8 +: 8];
        end
    endfunction

    // Load path: gather n bytes starting at lane off, wrapping within the word.
    function automatic logic [31:0] load_back(input logic [31:0] w, input int off, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = w[((off + i) % 4)*8 +: 8];
        return r;
    endfunction

    task automatic run_store(input vec_t v);
        int          n;
        int          off;
        logic [31:0] mask;
        n    = size_of(v.f3);
        off  = (v.f3 == 3'b010) ? 0 : int'(v.addr[1:0]);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
        check({v.name, ".ready_idle"}, 32'(bus.oready), 32'd1);
        bus.ivalid  = 1'b1;
        bus.iaddr   = v.addr;
        bus.iwdata  = v.data;
        bus.ifunct3 = v.f3;
        tick();
        if (v.rej) begin
            garbage();
            check({v.name, ".rej_req"},  32'(bus.omem_req), 32'd0);
            check({v.name, ".rej_be"},   32'(bus.omem_be),  32'd0);
            check({v.name, ".rej_done"}, 32'(bus.odone),    32'd1);
            check({v.name, ".rej_err"},  32'(bus.oerr),     32'd1);
        end else begin
            for (int c = 0; c < TO; c++) begin
                garbage();
                check({v.name, ".req"},   32'(bus.omem_req), 32'd1);
                check({v.name, ".done"},  32'(bus.odone),    32'd0);
                check({v.name, ".addr"},  bus.omem_addr,     v.exp_addr);
                check({v.name, ".be"},    32'(bus.omem_be),  32'(v.exp_be));
                check({v.name, ".wdata"}, bus.omem_wdata,    v.exp_wdata);
                if (c == 0) check({v.name, ".readback"}, load_back(bus.omem_wdata, off, n), v.data & mask);
                bus.imem_ack = (c == v.ack_at);
                tick();
                bus.imem_ack = 1'b0;
                if (c == v.ack_at) break;
            end
            garbage();
            check({v.name, ".fin_done"}, 32'(bus.odone),    32'd1);
            check({v.name, ".fin_err"},  32'(bus.oerr),     32'(v.exp_err));
            check({v.name, ".fin_req"},  32'(bus.omem_req), 32'd0);
            check({v.name, ".fin_be"},   32'(bus.omem_be),  32'd0);
        end
        tick();
        bus.ivalid = 1'b0;
        check({v.name, ".post_done"},  32'(bus.odone),  32'd0);
        check({v.name, ".post_err"},   32'(bus.oerr),   32'd0);
        check({v.name, ".post_ready"}, 32'(bus.oready), 32'd1);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst          = 1'b1;
        bus.ivalid   = 1'b0;
        bus.iaddr    = '0;
        bus.iwdata   = '0;
        bus.ifunct3  = '0;
        bus.imem_ack = 1'b0;
        tick();
        tick();
        check("rst.req",   32'(bus.omem_req), 32'd0);
        check("rst.be",    32'(bus.omem_be),  32'd0);
        check("rst.wdata", bus.omem_wdata,    32'd0);
        check("rst.addr",  bus.omem_addr,     32'd0);
        check("rst.done",  32'(bus.odone),    32'd0);
        check("rst.err",   32'(bus.oerr),     32'd0);
        check("rst.ready", 32'(bus.oready),   32'd1);
        rst = 1'b0;
        tick();

        //               name        addr          data          f3      ack rej   exp_addr      exp_wdata     be       err
        tbl.push_back('{"sb_off3",   32'h0000_1003, 32'hAABB_CCDD, 3'b000, 1,  1'b0, 32'h0000_1000, 32'hDD00_0000, 4'b1000, 1'b0});
        tbl.push_back('{"sb_off0",   32'h0000_0040, 32'h0000_0155, 3'b000, 0,  1'b0, 32'h0000_0040, 32'h0000_0055, 4'b0001, 1'b0});
        tbl.push_back('{"sb_off2",   32'h0000_0042, 32'h1234_5678, 3'b000, 3,  1'b0, 32'h0000_0040, 32'h0078_0000, 4'b0100, 1'b0});
        tbl.push_back('{"sh_off1",   32'h0000_0101, 32'h0000_BEEF, 3'b001, 0,  1'b0, 32'h0000_0100, 32'h00BE_EF00, 4'b0110, 1'b0});
        tbl.push_back('{"sh_off2",   32'h0000_0102, 32'hFFFF_ABCD, 3'b001, 2,  1'b0, 32'h0000_0100, 32'hABCD_0000, 4'b1100, 1'b0});
`ifdef STOREENC_ALIGN_CHECK_EN
        tbl.push_back('{"sh_off3",   32'h0000_0003, 32'h0000_1234, 3'b001, 0,  1'b1, 32'h0,         32'h0,         4'b0000, 1'b1});
        tbl.push_back('{"sw_off2",   32'h0000_2002, 32'hCAFE_F00D, 3'b010, 0,  1'b1, 32'h0,         32'h0,         4'b0000, 1'b1});
`else
        tbl.push_back('{"sh_off3",   32'h0000_0003, 32'h0000_1234, 3'b001, 0,  1'b0, 32'h0000_0000, 32'h3400_0012, 4'b1001, 1'b0});
        tbl.push_back('{"sw_off2",   32'h0000_2002, 32'hCAFE_F00D, 3'b010, 1,  1'b0, 32'h0000_2000, 32'hCAFE_F00D, 4'b1111, 1'b0});
`endif
        tbl.push_back('{"illegal3",  32'h0000_0010, 32'h1111_1111, 3'b011, 0,  1'b1, 32'h0,         32'h0,         4'b0000, 1'b1});
        tbl.push_back('{"illegal7",  32'h0000_0020, 32'h2222_2222, 3'b111, 0,  1'b1, 32'h0,         32'h0,         4'b0000, 1'b1});
        tbl.push_back('{"timeout",   32'h0000_0080, 32'h1234_5678, 3'b010, 99, 1'b0, 32'h0000_0080, 32'h1234_5678, 4'b1111, 1'b1});
        tbl.push_back('{"ack_last",  32'h0000_0080, 32'h8765_4321, 3'b010, 15, 1'b0, 32'h0000_0080, 32'h8765_4321, 4'b1111, 1'b0});

        foreach (tbl[i]) run_store(tbl[i]);

        // Synchronous reset in the third REQ cycle aborts without odone.
        bus.ivalid  = 1'b1;
        bus.iaddr   = 32'h0000_0010;
        bus.iwdata  = 32'h0000_0011;
        bus.ifunct3 = 3'b000;
        tick();
        bus.ivalid = 1'b0;
        check("rstmid.req_c1", 32'(bus.omem_req), 32'd1);
        tick();
        tick();
        check("rstmid.req_c3", 32'(bus.omem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid.req",   32'(bus.omem_req), 32'd0);
        check("rstmid.be",    32'(bus.omem_be),  32'd0);
        check("rstmid.ready", 32'(bus.oready),   32'd1);
        check("rstmid.done",  32'(bus.odone),    32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstmid.no_done", 32'(bus.odone), 32'd0);
        end
        run_store('{"after_rst", 32'h0000_0031, 32'h0000_00A5, 3'b000, 1, 1'b0,
                    32'h0000_0030, 32'h0000_A500, 4'b0010, 1'b0});

        // Randomized stores against the lane model.
        for (int i = 0; i < 150; i++) begin
            v.name   = "rand";
            v.addr   = $urandom;
            v.data   = $urandom;
            v.f3     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            v.ack_at = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? TO - 1 : 40)
                                                   : int'($urandom_range(0, 5));
            model(v.addr, v.data, v.f3, v.rej, v.exp_addr, v.exp_wdata, v.exp_be);
            v.exp_err = v.rej || (v.ack_at >= TO);
            run_store(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
